// File: rtl/deser_frame_unit.sv
// ============================================================================
// deser_frame_unit : run-time configurable UART RX frame deserializer
// Optional parity output built when DESER_PARITY_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module deser_frame_unit #(
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          frame_start,
  input  logic [LW-1:0] data_len,
  input  logic          msb_first,
  input  logic          deser_en,
  input  logic          sampled_bit,
`ifdef DESER_PARITY_EN
  input  logic          par_odd,
  output logic          par_bit,
`endif
  output logic [DW-1:0] p_data,
  output logic          p_valid,
  output logic          busy,
  output logic          frame_abort,
  output logic [LW-1:0] bit_cnt
);

  localparam logic [LW-1:0] C_DW_LEN = LW'(DW);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic          msb_q;
  logic [DW-1:0] shreg_q;
  logic [DW-1:0] p_data_q;
  logic          p_valid_q;
  logic          abort_q;

  logic [LW-1:0] len_d;
  logic [DW-1:0] shreg_d;
  logic [DW-1:0] word_d;
  logic          last_bit;

  // Zero and oversize lengths both collapse to a full-width frame.
  assign len_d = ((data_len == '0) || (data_len > C_DW_LEN)) ? C_DW_LEN : data_len;

  assign shreg_d = msb_q ? {shreg_q[DW-2:0], sampled_bit}
                         : (shreg_q | (DW'(sampled_bit) << cnt_q));

  assign word_d   = shreg_d & ({DW{1'b1}} >> (C_DW_LEN - len_q));
  assign last_bit = (state_q == SHIFT) && deser_en && (cnt_q == (len_q - 1'b1));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      len_q     <= C_DW_LEN;
      cnt_q     <= '0;
      msb_q     <= 1'b0;
      shreg_q   <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      p_valid_q <= 1'b0;
      abort_q   <= 1'b0;
      // A new frame request wins over any coincident data strobe.
      if (frame_start) begin
        abort_q <= (state_q == SHIFT);
        state_q <= SHIFT;
        len_q   <= len_d;
        msb_q   <= msb_first;
        shreg_q <= '0;
        cnt_q   <= '0;
      end else if (last_bit) begin
        p_data_q  <= word_d;
        p_valid_q <= 1'b1;
        state_q   <= IDLE;
        shreg_q   <= '0;
        cnt_q     <= '0;
      end else if ((state_q == SHIFT) && deser_en) begin
        shreg_q <= shreg_d;
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic par_odd_q;
  logic par_bit_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      par_odd_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (frame_start) begin
      par_odd_q <= par_odd;
    end else if (last_bit) begin
      par_bit_q <= (^word_d) ^ par_odd_q;
    end
  end

  assign par_bit = par_bit_q;
`endif

  assign p_data      = p_data_q;
  assign p_valid     = p_valid_q;
  assign busy        = (state_q == SHIFT);
  assign frame_abort = abort_q;
  assign bit_cnt     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_deser_frame_unit.sv
// ============================================================================
// tb_deser_frame_unit : directed, table-driven bench for deser_frame_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_deser_frame_unit;

  logic       clk = 1'b0;
  logic       RST;
  logic       frame_start;
  logic [3:0] data_len;
  logic       msb_first;
  logic       deser_en;
  logic       sampled_bit;
  logic [7:0] p_data;
  logic       p_valid;
  logic       busy;
  logic       frame_abort;
  logic [3:0] bit_cnt;
`ifdef DESER_PARITY_EN
  logic       par_odd;
  logic       par_bit;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  deser_frame_unit #(.DW(8), .LW(4)) dut (
    .clk         (clk),
    .RST         (RST),
    .frame_start (frame_start),
    .data_len    (data_len),
    .msb_first   (msb_first),
    .deser_en    (deser_en),
    .sampled_bit (sampled_bit),
`ifdef DESER_PARITY_EN
    .par_odd     (par_odd),
    .par_bit     (par_bit),
`endif
    .p_data      (p_data),
    .p_valid     (p_valid),
    .busy        (busy),
    .frame_abort (frame_abort),
    .bit_cnt     (bit_cnt)
  );

  typedef struct {
    logic        msb;
    logic [3:0]  len;
    int          nbits;
    logic [15:0] seq;   // seq[i] is the i-th bit on the wire
    int          gap;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic msb, input logic [3:0] len);
    frame_start = 1'b1;
    msb_first   = msb;
    data_len    = len;
    tick();
    frame_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("cnt_after_start", 32'(bit_cnt), 32'd0);
  endtask

  task automatic send_bits(input logic [15:0] seq, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) tick();
      deser_en    = 1'b1;
      sampled_bit = seq[i];
      tick();
      deser_en    = 1'b0;
    end
  endtask

  // Sends a whole frame and checks completion timing and the held word.
  task automatic send_frame(input string name, input logic [15:0] seq, input int n,
                            input int gap, input logic [7:0] exp);
    logic bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        if (p_valid) bad = 1'b1;
      end
      deser_en    = 1'b1;
      sampled_bit = seq[i];
      tick();
      deser_en    = 1'b0;
      if (i < n - 1) begin
        if (p_valid || (32'(bit_cnt) != i + 1) || !busy) bad = 1'b1;
      end
    end
    chk({name, "_progress"}, 32'(bad), 32'd0);
    chk({name, "_valid"}, 32'(p_valid), 32'd1);
    chk({name, "_data"}, 32'(p_data), 32'(exp));
    chk({name, "_idle"}, {30'd0, busy, |bit_cnt}, 32'd0);
    tick();
    chk({name, "_valid_drop"}, 32'(p_valid), 32'd0);
    chk({name, "_data_hold"}, 32'(p_data), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{msb: 1'b0, len: 4'd8,  nbits: 8, seq: 16'h00A5, gap: 2, exp: 8'hA5};
    vecs[1] = '{msb: 1'b1, len: 4'd5,  nbits: 5, seq: 16'h000D, gap: 0, exp: 8'h16};
    vecs[2] = '{msb: 1'b0, len: 4'd0,  nbits: 8, seq: 16'h003C, gap: 1, exp: 8'h3C};
    vecs[3] = '{msb: 1'b1, len: 4'd12, nbits: 8, seq: 16'h0083, gap: 0, exp: 8'hC1};
    vecs[4] = '{msb: 1'b0, len: 4'd3,  nbits: 3, seq: 16'h0003, gap: 3, exp: 8'h03};
    vecs[5] = '{msb: 1'b1, len: 4'd2,  nbits: 2, seq: 16'h0002, gap: 0, exp: 8'h01};

    RST = 1'b0; frame_start = 1'b0; data_len = 4'd8; msb_first = 1'b0;
    deser_en = 1'b0; sampled_bit = 1'b0;
`ifdef DESER_PARITY_EN
    par_odd = 1'b0;
`endif
    repeat (2) tick();
    chk("reset_outputs", {p_data, p_valid, busy, frame_abort, bit_cnt}, 32'd0);
    RST = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      start_frame(vecs[v].msb, vecs[v].len);
      send_frame($sformatf("vec%0d", v), vecs[v].seq, vecs[v].nbits, vecs[v].gap, vecs[v].exp);
    end

    // Restart after 3 bits: abort pulse, then the new frame completes once.
    start_frame(1'b0, 4'd8);
    send_bits(16'h0007, 3, 0);
    frame_start = 1'b1; data_len = 4'd8; msb_first = 1'b0;
    tick();
    frame_start = 1'b0;
    chk("abort_pulse", {30'd0, frame_abort, p_valid}, 32'd2);
    chk("abort_restart", {27'd0, busy, bit_cnt}, 32'h10);
    tick();
    chk("abort_drop", 32'(frame_abort), 32'd0);
    send_frame("after_abort", 16'h003C, 8, 0, 8'h3C);

    // Restart coinciding with the last bit: no completion.
    start_frame(1'b0, 4'd3);
    send_bits(16'h0003, 2, 0);
    frame_start = 1'b1; deser_en = 1'b1; sampled_bit = 1'b1; data_len = 4'd3;
    tick();
    frame_start = 1'b0; deser_en = 1'b0;
    chk("lastbit_abort", {30'd0, frame_abort, p_valid}, 32'd2);
    chk("lastbit_data_held", 32'(p_data), 32'h3C);
    chk("lastbit_restart", {27'd0, busy, bit_cnt}, 32'h10);
    send_frame("lastbit_new", 16'h0005, 3, 0, 8'h05);

    // Asynchronous reset in the middle of a frame.
    start_frame(1'b0, 4'd8);
    send_bits(16'h0007, 3, 0);
    chk("pre_reset_cnt", 32'(bit_cnt), 32'd3);
    RST = 1'b0;
    #1;
    chk("async_reset", {p_data, p_valid, busy, frame_abort, bit_cnt}, 32'd0);
    deser_en = 1'b1;
    tick();
    tick();
    deser_en = 1'b0;
    RST = 1'b1;
    tick();
    chk("post_reset_idle", {p_data, p_valid, busy, frame_abort, bit_cnt}, 32'd0);

    // IDLE strobes are ignored.
    start_frame(1'b1, 4'd4);
    send_frame("nibble", 16'h0009, 4, 0, 8'h09);
    deser_en = 1'b1; sampled_bit = 1'b1;
    repeat (4) tick();
    deser_en = 1'b0;
    chk("idle_strobes", {p_data, p_valid, busy, bit_cnt}, {24'd0, 8'h09} << 6);

    // Bit coinciding with frame_start is not captured.
    frame_start = 1'b1; deser_en = 1'b1; sampled_bit = 1'b1;
    data_len = 4'd2; msb_first = 1'b0;
    tick();
    frame_start = 1'b0; deser_en = 1'b0;
    chk("start_drop_cnt", {27'd0, busy, bit_cnt}, 32'h10);
    send_frame("start_drop", 16'h0000, 2, 0, 8'h00);

`ifdef DESER_PARITY_EN
    par_odd = 1'b0;
    start_frame(1'b0, 4'd8);
    send_frame("par_even", 16'h00A5, 8, 0, 8'hA5);
    chk("par_even_bit", 32'(par_bit), 32'd0);
    par_odd = 1'b1;
    start_frame(1'b0, 4'd8);
    send_frame("par_odd", 16'h00A5, 8, 0, 8'hA5);
    chk("par_odd_bit", 32'(par_bit), 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
